// File: rtl/ff_bank_pkg.sv
// rtl/ff_bank_pkg.sv - mode encodings and reset default for the multi-mode flop bank
package ff_bank_pkg;

  localparam logic [1:0] MODE_D  = 2'd0;
  localparam logic [1:0] MODE_T  = 2'd1;
  localparam logic [1:0] MODE_JK = 2'd2;
  localparam logic [1:0] MODE_SR = 2'd3;

  // Replicated per bit to build the default RESET_VAL at any WIDTH.
  localparam logic RESET_BIT_DEFAULT = 1'b0;

endpackage

// File: rtl/ff_bank_next.sv
// rtl/ff_bank_next.sv - per-bit next-state and illegal-SR detect cell
module ff_bank_next
  import ff_bank_pkg::*;
(
  input  logic [1:0] mode,
  input  logic       q,
  input  logic       a,
  input  logic       b,
  output logic       q_next,
  output logic       illegal
);

  always_comb begin
    q_next  = q;
    illegal = 1'b0;
    unique case (mode)
      MODE_D:  q_next = a;
      MODE_T:  q_next = q ^ a;
      MODE_JK: begin
        unique case ({a, b})
          2'b00:   q_next = q;
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          default: q_next = ~q;
        endcase
      end
      default: begin
        // S=R=1 keeps the stored value so q never goes unknown.
        unique case ({a, b})
          2'b00:   q_next = q;
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          default: begin
            q_next  = q;
            illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/ff_bank.sv
// rtl/ff_bank.sv - WIDTH-bit D/T/JK/SR flop bank with sticky SR error and change pulse
module ff_bank
  import ff_bank_pkg::*;
#(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{RESET_BIT_DEFAULT}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             err,
  output logic [WIDTH-1:0] err_mask,
  output logic             changed
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] err_mask_q, err_mask_d;
  logic             changed_q, changed_d;
  logic [WIDTH-1:0] cell_next;
  logic [WIDTH-1:0] cell_illegal;
  logic [WIDTH-1:0] illegal_vec;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_bank_next u_next (
      .mode    (mode),
      .q       (q_q[i]),
      .a       (a[i]),
      .b       (b[i]),
      .q_next  (cell_next[i]),
      .illegal (cell_illegal[i])
    );
  end

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = cell_next;
    end
  end

  assign illegal_vec = (en && !clr) ? cell_illegal : '0;

  // A fresh illegal combination wins over err_clr in the same cycle.
  always_comb begin
    err_d      = err_q;
    err_mask_d = err_mask_q;
    if (|illegal_vec) begin
      err_d      = 1'b1;
      err_mask_d = err_clr ? illegal_vec : (err_mask_q | illegal_vec);
    end else if (err_clr) begin
      err_d      = 1'b0;
      err_mask_d = '0;
    end
  end

  always_comb begin
    changed_d = (q_d != q_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q        <= RESET_VAL;
      err_q      <= 1'b0;
      err_mask_q <= '0;
      changed_q  <= 1'b0;
    end else begin
      q_q        <= q_d;
      err_q      <= err_d;
      err_mask_q <= err_mask_d;
      changed_q  <= changed_d;
    end
  end

  assign q        = q_q;
  assign qb       = ~q_q;
  assign err      = err_q;
  assign err_mask = err_mask_q;
  assign changed  = changed_q;

endmodule

// File: tb/tb_ff_bank.sv
// tb/tb_ff_bank.sv - directed self-checking bench for ff_bank
module tb_ff_bank;

  localparam logic [1:0] M_D  = 2'd0;
  localparam logic [1:0] M_T  = 2'd1;
  localparam logic [1:0] M_JK = 2'd2;
  localparam logic [1:0] M_SR = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic       en;
  logic       clr;
  logic [7:0] a;
  logic [7:0] b;
  logic       err_clr;
  logic [7:0] q;
  logic [7:0] qb;
  logic       err;
  logic [7:0] err_mask;
  logic       changed;

  int total = 0;
  int bad   = 0;

  ff_bank #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .en       (en),
    .clr      (clr),
    .a        (a),
    .b        (b),
    .err_clr  (err_clr),
    .q        (q),
    .qb       (qb),
    .err      (err),
    .err_mask (err_mask),
    .changed  (changed)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [7:0] v);
    mode = M_D; en = 1'b1; clr = 1'b0; err_clr = 1'b0; a = v; b = 8'h00;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0; mode = M_D; en = 1'b0; clr = 1'b0; a = 8'h00; b = 8'h00; err_clr = 1'b0;
    step();
    step();
    total++; if (q !== 8'h00) begin bad++; $display("FAIL reset_q got=%h exp=00", q); end
    total++; if (qb !== 8'hFF) begin bad++; $display("FAIL reset_qb got=%h exp=FF", qb); end
    total++; if (err !== 1'b0 || err_mask !== 8'h00) begin bad++; $display("FAIL reset_err got=%b/%h exp=0/00", err, err_mask); end
    total++; if (changed !== 1'b0) begin bad++; $display("FAIL reset_changed got=%b exp=0", changed); end
  endtask

  task automatic test_d_mode();
    rst = 1'b1;
    mode = M_D; en = 1'b1; a = 8'hA5;
    step();
    total++; if (q !== 8'hA5 || qb !== 8'h5A) begin bad++; $display("FAIL d_load got=%h/%h exp=A5/5A", q, qb); end
    total++; if (changed !== 1'b1) begin bad++; $display("FAIL d_changed got=%b exp=1", changed); end
    step();
    total++; if (q !== 8'hA5 || changed !== 1'b0) begin bad++; $display("FAIL d_steady got=%h/%b exp=A5/0", q, changed); end
  endtask

  task automatic test_t_mode();
    mode = M_T; a = 8'h0F;
    step();
    total++; if (q !== 8'hAA || changed !== 1'b1) begin bad++; $display("FAIL t_first got=%h/%b exp=AA/1", q, changed); end
    step();
    total++; if (q !== 8'hA5 || changed !== 1'b1) begin bad++; $display("FAIL t_second got=%h/%b exp=A5/1", q, changed); end
  endtask

  task automatic test_jk_mode();
    load(8'hF0);
    mode = M_JK; a = 8'hCC; b = 8'hAA;
    step();
    total++; if (q !== 8'h5C || changed !== 1'b1) begin bad++; $display("FAIL jk_mix got=%h/%b exp=5C/1", q, changed); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL jk_no_err got=%b exp=0", err); end
  endtask

  task automatic test_sr_illegal();
    load(8'h3C);
    mode = M_SR; a = 8'h81; b = 8'h01;
    step();
    total++; if (q !== 8'hBC) begin bad++; $display("FAIL sr_q got=%h exp=BC", q); end
    total++; if (err !== 1'b1 || err_mask !== 8'h01) begin bad++; $display("FAIL sr_err1 got=%b/%h exp=1/01", err, err_mask); end
    a = 8'h02; b = 8'h02;
    step();
    total++; if (err_mask !== 8'h03 || q !== 8'hBC || changed !== 1'b0) begin bad++; $display("FAIL sr_accum got=%h/%h/%b exp=03/BC/0", err_mask, q, changed); end
    a = 8'h80; b = 8'h80; err_clr = 1'b1;
    step();
    total++; if (err !== 1'b1 || err_mask !== 8'h80) begin bad++; $display("FAIL sr_clr_race got=%b/%h exp=1/80", err, err_mask); end
    err_clr = 1'b0; clr = 1'b1;
    step();
    total++; if (q !== 8'h00 || err !== 1'b1 || err_mask !== 8'h80) begin bad++; $display("FAIL sr_clr_keeps_err got=%h/%b/%h exp=00/1/80", q, err, err_mask); end
    clr = 1'b0; a = 8'h00; b = 8'h00; err_clr = 1'b1;
    step();
    total++; if (err !== 1'b0 || err_mask !== 8'h00) begin bad++; $display("FAIL sr_err_clr got=%b/%h exp=0/00", err, err_mask); end
    err_clr = 1'b0;
  endtask

  task automatic test_priority();
    load(8'hFF);
    en = 1'b0; clr = 1'b1; a = 8'h12;
    step();
    total++; if (q !== 8'h00 || changed !== 1'b1) begin bad++; $display("FAIL prio_clr got=%h/%b exp=00/1", q, changed); end
    clr = 1'b0; mode = M_SR; a = 8'hFF; b = 8'hFF;
    step();
    total++; if (q !== 8'h00 || changed !== 1'b0) begin bad++; $display("FAIL prio_hold got=%h/%b exp=00/0", q, changed); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL prio_no_err got=%b exp=0", err); end
  endtask

  task automatic test_async_reset();
    load(8'h00);
    mode = M_SR; a = 8'h01; b = 8'h01;
    step();
    mode = M_T; a = 8'hFF; b = 8'h00;
    step();
    total++; if (q !== 8'hFF || err !== 1'b1) begin bad++; $display("FAIL ar_pre got=%h/%b exp=FF/1", q, err); end
    #2 rst = 1'b0;
    #1;
    total++; if (q !== 8'h00 || qb !== 8'hFF || err !== 1'b0 || err_mask !== 8'h00 || changed !== 1'b0) begin
      bad++; $display("FAIL ar_immediate got=%h/%h/%b/%h/%b exp=00/FF/0/00/0", q, qb, err, err_mask, changed);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    total++; if (q !== 8'hFF || changed !== 1'b1) begin bad++; $display("FAIL ar_resume got=%h/%b exp=FF/1", q, changed); end
    step();
    total++; if (q !== 8'h00 || changed !== 1'b1) begin bad++; $display("FAIL ar_resume2 got=%h/%b exp=00/1", q, changed); end
  endtask

  initial begin
    test_reset();
    test_d_mode();
    test_t_mode();
    test_jk_mode();
    test_sr_illegal();
    test_priority();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ff_bank.md
# ff_bank

Parametrised multi-mode flip-flop bank: WIDTH independent storage bits, with per-cycle selectable D, T, JK or SR behaviour. The bank replaces individual single-bit D/T/JK/SR flops wherever the design needs a register with selectable update semantics. It adds:
- a sticky illegal-SR error detector with a per-bit capture mask;
- a registered change-detect pulse.

It sits between control logic and any status or state register that needs mixed update semantics.

## Interface
Parameters:
- WIDTH, 8, number of storage bits (1..64)
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset: rst=0 resets immediately, independent of clk
- mode  in  2  update mode; encoding is in ff_bank_pkg
- en  in  1  update enable; en=0 holds q
- clr  in  1  synchronous clear of q to all zeros; overrides en and mode
- a  in  WIDTH  per-bit primary input: d, t, j or s depending on mode
- b  in  WIDTH  per-bit secondary input: k or r; ignored in D and T modes
- err_clr  in  1  synchronous clear of err and err_mask
- q  out  WIDTH  register state
- qb  out  WIDTH  combinational ~q
- err  out  1  sticky flag: an illegal SR combination was applied
- err_mask  out  WIDTH  sticky OR of the bits that saw an illegal SR combination
- changed  out  1  one-cycle pulse: q changed on the previous edge

## Operation
- Reset (rst=0): q=RESET_VAL, qb=~RESET_VAL, err=0, err_mask=0, changed=0. All are held while rst=0; leaving reset is synchronous to clk.
- Update priority on each rising edge: clr, then en=0 (hold), then mode.
- Per-bit next state when en=1 and clr=0:
  - D: q'=a.
  - T: q'=q^a.
  - JK (a=j, b=k): 00 hold, 01 clear, 10 set, 11 toggle.
  - SR (a=s, b=r): 00 hold, 01 clear, 10 set, 11 illegal.
- Illegal SR on a bit: that bit holds its current value (never X); it is flagged for the error logic.
- Error logic:
  - illegal_vec = bits with a=b=1, qualified by mode==SR, en=1, clr=0.
  - If illegal_vec≠0: err←1 and err_mask←err_mask|illegal_vec.
  - If err_clr=1 in the same cycle as illegal_vec≠0: err←1 and err_mask←illegal_vec. New errors win over the clear.
  - err_clr with no new error: err←0, err_mask←0.
  - clr does not affect err or err_mask.
- changed←(q_next≠q) on every edge, including edges caused by clr. changed=0 when q_next==q.
- A mode change takes effect on the same edge at which it is sampled. No pipeline and no mode history.

## Timing
- q, err, err_mask and changed are all registered. Latency is one clock from inputs to q.
- qb follows q combinationally, with zero added cycles.
- changed is asserted in the cycle after the edge at which q changed, aligned with the new q value.
- Asserting rst mid-operation clears everything asynchronously. The first edge after rst rises applies normal update rules to q=RESET_VAL.
- No handshake. Inputs are sampled on every rising edge.

## Structure
- ff_bank_pkg holds:
  - the mode localparams MODE_D=2'd0, MODE_T=2'd1, MODE_JK=2'd2, MODE_SR=2'd3;
  - the function or localparam used for the default RESET_VAL.
- Sub-module ff_bank_next: a combinational per-bit next-state and illegal-detect cell with inputs (mode, q, a, b) and outputs (q_next, illegal). It is instantiated WIDTH times with a generate loop.
- The top level holds the q register, the error registers, the changed register and the qb assign.

## Test plan
All scenarios use WIDTH=8 and RESET_VAL=8'h00.
1. Reset and D mode:
   - Hold rst=0 → q=00, qb=FF, err=0, changed=0.
   - Release rst; mode=D, en=1, a=A5 → q=A5 next cycle, changed=1, then changed=0 with a held at A5.
2. T mode: from q=A5, mode=T, a=0F for 2 edges → q=AA, then A5; changed=1 both cycles.
3. JK mode: from q=F0, mode=JK, a=CC, b=AA → bits (j,k) give q=5C (11→toggle, 10→set, 01→clear, 00→hold).
4. SR illegal:
   - From q=3C, mode=SR, a=81, b=01 → bit0 holds; q=BC, err=1, err_mask=01.
   - Next cycle a=b=02 → err_mask=03.
   - Then err_clr with a=b=80 → err_mask=80, err=1.
   - Then err_clr alone → err=0, err_mask=00.
5. Priority: q=FF with en=0 and clr=1 → q=00, changed=1. With en=0, clr=0 and any a/b → q holds, changed=0.
6. Async reset mid-stream: in T mode toggling, drive rst=0 between edges → q=00, err=0 immediately without waiting for a clock edge; operation resumes correctly after release.
